// File: rtl/dbg_reg_arbiter.sv
// Two-requester arbiter for the register file debug read port.
// Requester 0 (VGA) may claim absolute priority while urgent; requester 1
// (monitor) is protected by a saturating wait counter. Read data returns
// through a registered req/ack handshake one cycle after the grant.
module dbg_reg_arbiter #(
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_urgent,
    input  logic [4:0]  r0_addr,
    output logic        r0_ack,
    output logic [31:0] r0_data,
    input  logic        r1_req,
    input  logic [4:0]  r1_addr,
    output logic        r1_ack,
    output logic [31:0] r1_data,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        gnt_id
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREQ   = 2;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        INFL = 2'd2
    } req_state_t;

    req_state_t        st_q   [NREQ];
    req_state_t        st_d   [NREQ];
    logic [CNT_W-1:0]  cnt_q  [NREQ];
    logic [CNT_W-1:0]  cnt_d  [NREQ];
    logic [ADDR_W-1:0] addr_v [NREQ];
    logic [NREQ-1:0]   req_v;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   gnt_vec;
    logic              gnt_vld;
    logic              gnt_sel;
    logic              last_gnt;

    assign req_v     = {r1_req, r0_req};
    assign addr_v[0] = r0_addr;
    assign addr_v[1] = r1_addr;

    // Winner selection, per-requester next state and wait counter update
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
        end

        // A requester whose read is in flight sits out this cycle
        elig[0] = req_v[0] && (st_q[0] != INFL);
        elig[1] = req_v[1] && (st_q[1] != INFL);

        if (elig[0] && !elig[1]) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b0;
        end else if (!elig[0] && elig[1]) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
        end else if (elig[0] && elig[1]) begin
            gnt_vld = 1'b1;
            if (r0_urgent) begin
                gnt_sel = 1'b0;
            end else if (cnt_q[0] >= LIM) begin
                gnt_sel = 1'b0;
            end else if (cnt_q[1] >= LIM) begin
                gnt_sel = 1'b1;
            end else begin
                gnt_sel = ~last_gnt;
            end
        end

        gnt_vec = gnt_vld ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;

        for (int i = 0; i < int'(NREQ); i++) begin
            case (st_q[i])
                IDLE: begin
                    if (req_v[i]) begin
                        st_d[i] = gnt_vec[i] ? INFL : PEND;
                    end
                end
                PEND: begin
                    if (!req_v[i]) begin
                        st_d[i] = IDLE;
                    end else if (gnt_vec[i]) begin
                        st_d[i] = INFL;
                    end
                end
                INFL: begin
                    st_d[i] = IDLE;
                end
                default: begin
                    st_d[i] = IDLE;
                end
            endcase

            if (gnt_vec[i] || !req_v[i]) begin
                cnt_d[i] = '0;
            end else if (elig[i] && (cnt_q[i] < LIM)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]  <= IDLE;
            st_q[1]  <= IDLE;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            last_gnt <= 1'b1;
        end else begin
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            if (gnt_vld) begin
                last_gnt <= gnt_sel;
            end
        end
    end

    // Launch the granted read: address to the register file and owner id
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regAddr <= '0;
            gnt_id  <= 1'b0;
        end else if (gnt_vld) begin
            regAddr <= addr_v[gnt_sel];
            gnt_id  <= gnt_sel;
        end
    end

    // Return data to whichever requester has its read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            r0_data <= '0;
            r1_data <= '0;
        end else begin
            r0_ack <= (st_q[0] == INFL);
            r1_ack <= (st_q[1] == INFL);
            if (st_q[0] == INFL) begin
                r0_data <= regData;
            end
            if (st_q[1] == INFL) begin
                r1_data <= regData;
            end
        end
    end

endmodule
